// File: rtl/checkpoint_ctrl_pkg.sv
// checkpoint_ctrl_pkg: shared types and sizes for the branch checkpoint controller
package checkpoint_ctrl_pkg;
  localparam int CKPT_NUM = 8;
  localparam int CKPT_IDX_W = $clog2(CKPT_NUM);
  localparam int CKPT_TAG_W = 4;
  typedef logic [CKPT_IDX_W-1:0] ckpt_idx_t;
  typedef logic [CKPT_TAG_W-1:0] rob_tag_t;
  typedef enum logic {CK_RUN, CK_RECOVER} ckpt_state_e;
endpackage

// File: rtl/checkpoint_ctrl_tag_match.sv
// ckpt_tag_match: oldest-first CAM of a ROB tag over the live checkpoint slots
module ckpt_tag_match
  import checkpoint_ctrl_pkg::*;
#(
  parameter int NUM_CKPT = CKPT_NUM,
  parameter int IDX_W = $clog2(NUM_CKPT),
  parameter int TAG_W = CKPT_TAG_W
) (
  input  logic [NUM_CKPT-1:0] valid,
  input  logic [TAG_W-1:0]    tags [NUM_CKPT],
  input  logic [IDX_W-1:0]    head,
  input  logic [TAG_W-1:0]    key,
  output logic                hit,
  output logic [IDX_W-1:0]    idx
);
  logic [IDX_W-1:0] s;
  // Walk youngest to oldest so the match nearest head is written last.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    s = '0;
    for (int i = NUM_CKPT - 1; i >= 0; i--) begin
      s = head + IDX_W'(i);
      if (valid[s] && tags[s] == key) begin
        hit = 1'b1;
        idx = s;
      end
    end
  end
endmodule

// File: rtl/checkpoint_ctrl.sv
// checkpoint_ctrl: in-order allocation, retirement and mispredict recovery of branch checkpoint slots
module checkpoint_ctrl
  import checkpoint_ctrl_pkg::*;
#(
  parameter int NUM_CKPT = CKPT_NUM,
  parameter int IDX_W = $clog2(NUM_CKPT),
  parameter int TAG_W = CKPT_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  input  logic [TAG_W-1:0] alloc_tag,
  output logic             alloc_gnt,
  output logic [IDX_W-1:0] alloc_idx,
  output logic             ckpt_full,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_mispred,
  output logic             restore_valid,
  output logic [IDX_W-1:0] restore_idx,
  output logic             tag_miss,
  output logic [IDX_W:0]   occupancy
);
  ckpt_state_e          state;
  logic [IDX_W-1:0]     head, tail, hit_idx;
  logic [IDX_W:0]       count;
  logic [NUM_CKPT-1:0]  valid, done, kill;
  logic [TAG_W-1:0]     tag [NUM_CKPT];
  logic                 hit, run, mis, retire;
  ckpt_tag_match #(.NUM_CKPT(NUM_CKPT), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_match (
    .valid(valid), .tags(tag), .head(head), .key(resolve_tag), .hit(hit), .idx(hit_idx)
  );
  assign run = state == CK_RUN;
  assign mis = resolve_valid && resolve_mispred;
  assign ckpt_full = count == (IDX_W+1)'(NUM_CKPT);
  assign alloc_gnt = alloc_req && !ckpt_full && run && !mis;
  assign alloc_idx = tail;
  assign occupancy = count;
  assign retire = run && count != '0 && valid[head] && done[head] && !(mis && hit);
  // Slots at or beyond the mispredicted one in age order are squashed.
  always_comb begin
    kill = '0;
    for (int j = 0; j < NUM_CKPT; j++)
      kill[j] = valid[j] && IDX_W'(IDX_W'(j) - head) >= IDX_W'(hit_idx - head);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CK_RUN;
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
      done <= '0;
      for (int i = 0; i < NUM_CKPT; i++) tag[i] <= '0;
      restore_valid <= 1'b0;
      restore_idx <= '0;
      tag_miss <= 1'b0;
    end else if (!run) begin
      state <= CK_RUN;
      restore_valid <= 1'b0;
      tag_miss <= 1'b0;
    end else begin
      tag_miss <= resolve_valid && !hit;
      if (mis && hit) begin
        state <= CK_RECOVER;
        restore_valid <= 1'b1;
        restore_idx <= hit_idx;
        valid <= valid & ~kill;
        done <= done & ~kill;
        tail <= hit_idx;
        count <= {1'b0, IDX_W'(hit_idx - head)};
      end else begin
        if (resolve_valid && hit) done[hit_idx] <= 1'b1;
        if (alloc_gnt) begin
          valid[tail] <= 1'b1;
          done[tail] <= 1'b0;
          tag[tail] <= alloc_tag;
          tail <= tail + IDX_W'(1);
        end
        if (retire) begin
          valid[head] <= 1'b0;
          done[head] <= 1'b0;
          head <= head + IDX_W'(1);
        end
        count <= count + (IDX_W+1)'(alloc_gnt) - (IDX_W+1)'(retire);
      end
    end
  end
endmodule

// File: tb/tb_checkpoint_ctrl.sv
// tb_checkpoint_ctrl: scoreboard bench for checkpoint_ctrl with hand-derived expectations
module tb_checkpoint_ctrl;
  import checkpoint_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset, alloc_req, resolve_valid, resolve_mispred;
  rob_tag_t alloc_tag, resolve_tag;
  logic alloc_gnt, ckpt_full, restore_valid, tag_miss;
  ckpt_idx_t alloc_idx, restore_idx;
  logic [CKPT_IDX_W:0] occupancy;
  int errors = 0;
  int checks = 0;
  int stepn = 0;
  typedef struct {int occ; int rv; int ridx; int miss;} exp_t;
  exp_t sb[$];
  checkpoint_ctrl dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_tag(alloc_tag),
    .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx), .ckpt_full(ckpt_full),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_mispred(resolve_mispred),
    .restore_valid(restore_valid), .restore_idx(restore_idx),
    .tag_miss(tag_miss), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, stepn, got, exp);
    end
  endtask
  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    check("occupancy", int'(occupancy), e.occ);
    check("restore_valid", int'(restore_valid), e.rv);
    check("restore_idx", int'(restore_idx), e.ridx);
    check("tag_miss", int'(tag_miss), e.miss);
  endtask
  task automatic do_reset();
    stepn++;
    reset = 1'b0; alloc_req = 1'b0; alloc_tag = '0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_mispred = 1'b0;
    sb.push_back('{0, 0, 0, 0});
    @(posedge clk); #1;
    pop_check();
  endtask
  task automatic step(input logic rn, input logic req, input int atag,
                      input logic rvld, input int rtag, input logic mis,
                      input int e_gnt, input int e_idx, input int e_full,
                      input int e_occ, input int e_rv, input int e_ridx, input int e_miss);
    stepn++;
    reset = rn; alloc_req = req; alloc_tag = rob_tag_t'(atag);
    resolve_valid = rvld; resolve_tag = rob_tag_t'(rtag); resolve_mispred = mis;
    sb.push_back('{e_occ, e_rv, e_ridx, e_miss});
    @(negedge clk);
    check("alloc_gnt", int'(alloc_gnt), e_gnt);
    check("alloc_idx", int'(alloc_idx), e_idx);
    check("ckpt_full", int'(ckpt_full), e_full);
    @(posedge clk); #1;
    pop_check();
  endtask
  initial begin
    reset = 1'b0; alloc_req = 1'b0; alloc_tag = '0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_mispred = 1'b0;
    #1;
    do_reset();
    // fill all eight slots, then one more request must be refused
    for (int i = 0; i < 8; i++) step(1, 1, i, 0, 0, 0, 1, i, 0, i + 1, 0, 0, 0);
    step(1, 1, 8, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    // out-of-order correct resolves; retire only once the head is done
    step(1, 0, 0, 1, 2, 0, 0, 0, 1, 8, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
    step(1, 1, 15, 1, 1, 0, 0, 0, 1, 7, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    // mispredict on the head slot (3) empties the store and rewinds tail to 3
    step(1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0);
    step(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 3, 0);
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, i, 0, 0, 0, 1, i, 0, i + 1, 0, 0, 0);
    step(1, 0, 0, 1, 3, 1, 0, 6, 0, 3, 1, 3, 0);
    step(1, 1, 10, 0, 0, 0, 0, 3, 0, 3, 0, 3, 0);
    step(1, 1, 11, 0, 0, 0, 1, 3, 0, 4, 0, 3, 0);
    // wrap: retire six slots so head reaches 6, then allocate across the end
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, i, 0, 0, 0, 1, i, 0, i + 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, i, 0, 0, 6, 0, (i == 0) ? 6 : 6 - i, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 6 + i, 0, 0, 0, 1, (6 + i) % 8, 0, i + 1, 0, 0, 0);
    step(1, 0, 0, 1, 8, 1, 0, 2, 0, 2, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    // unmatched resolve, then mispredict that blocks a same-cycle alloc
    step(1, 0, 0, 1, 9, 0, 0, 0, 0, 2, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0);
    step(1, 1, 12, 1, 7, 1, 0, 0, 0, 1, 1, 7, 0);
    // reset asserted during recovery
    step(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0);
    step(1, 1, 3, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 4, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0);
    step(1, 0, 0, 1, 3, 1, 0, 2, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
